// File: rtl/sysbus_arbiter.sv
// Sysbus arbiter: shares one Sysbus request/response channel between the
// instruction-fetch port (0) and the data port (1). One transaction is in
// flight at a time. Writes stream BEATS data beats after the address phase.
// Read responses are routed back to the owning port.
module sysbus_arbiter #(
   parameter int unsigned BEATS  = 8,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned TAG_W  = 13
) (
   input  logic              clk,
   input  logic              reset,
   // requester side
   input  logic [1:0]        rq_valid,
   input  logic [DATA_W-1:0] rq_addr0,
   input  logic [DATA_W-1:0] rq_addr1,
   input  logic [4:0]        rq_type0,
   input  logic [4:0]        rq_type1,
   output logic [1:0]        rq_ack,
   input  logic [DATA_W-1:0] wd_data0,
   input  logic [DATA_W-1:0] wd_data1,
   output logic [1:0]        wd_pop,
   output logic [1:0]        rs_valid,
   output logic [DATA_W-1:0] rs_data,
   output logic              rs_last,
   output logic [1:0]        done,
   // Sysbus side
   output logic              bus_reqcyc,
   output logic [DATA_W-1:0] bus_req,
   output logic [TAG_W-1:0]  bus_reqtag,
   input  logic              bus_reqack,
   input  logic              bus_respcyc,
   input  logic [DATA_W-1:0] bus_resp,
   input  logic [TAG_W-1:0]  bus_resptag,
   output logic              bus_respack
);

   localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned LINE_OFS = 6;
   localparam int unsigned ID_W     = TAG_W - 5;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WDATA,
      WAIT,
      RESP
   } state_t;

   state_t                     state, state_nxt;
   logic [CNT_W-1:0]           count, count_nxt;
   logic                       owner;
   logic                       last_grant;
   logic [DATA_W-1:LINE_OFS]   line_addr;
   logic [4:0]                 req_type;
   logic                       grant;
   logic                       tag_match;
   logic                       take_beat;
   logic                       tag_err;

   // Line-offset address bits and the rw/type field of the response tag
   // carry no routing information here.
   logic unused_bits;
   assign unused_bits = ^{rq_addr0[LINE_OFS-1:0], rq_addr1[LINE_OFS-1:0],
                          bus_resptag[TAG_W-1:ID_W]};

   assign tag_match = (bus_resptag[ID_W-1:0] == ID_W'(owner));

   // Round-robin pick: on a tie the port that did not win last time goes.
   always_comb begin
      grant = 1'b0;
      if (rq_valid == 2'b11) begin
         grant = ~last_grant;
      end else if (rq_valid[1]) begin
         grant = 1'b1;
      end
   end

   // Capture the winning request when leaving IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner      <= 1'b0;
         last_grant <= 1'b1;
         line_addr  <= '0;
         req_type   <= '0;
      end else if (state == IDLE && |rq_valid) begin
         owner      <= grant;
         last_grant <= grant;
         line_addr  <= grant ? rq_addr1[DATA_W-1:LINE_OFS] : rq_addr0[DATA_W-1:LINE_OFS];
         req_type   <= grant ? rq_type1 : rq_type0;
      end
   end

   // State and beat counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // Next-state and output decode; every output is a function of state so
   // that reset clears them immediately.
   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      rq_ack      = '0;
      wd_pop      = '0;
      rs_valid    = '0;
      rs_data     = '0;
      rs_last     = 1'b0;
      done        = '0;
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      take_beat   = 1'b0;
      tag_err     = 1'b0;

      unique case (state)
         IDLE: begin
            count_nxt = '0;
            if (|rq_valid) begin
               state_nxt = REQ;
            end
         end

         REQ: begin
            bus_reqcyc = 1'b1;
            bus_req    = {line_addr, {LINE_OFS{1'b0}}};
            bus_reqtag = {req_type, ID_W'(owner)};
            if (bus_reqack) begin
               rq_ack[owner] = 1'b1;
               count_nxt     = '0;
               if (req_type[4]) begin
                  // pop now so beat 0 is on wd_data in the first WDATA cycle
                  wd_pop[owner] = 1'b1;
                  state_nxt     = WDATA;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end

         WDATA: begin
            bus_reqcyc = 1'b1;
            bus_req    = owner ? wd_data1 : wd_data0;
            if (count == LAST_BEAT) begin
               done[owner] = 1'b1;
               count_nxt   = '0;
               state_nxt   = IDLE;
            end else begin
               wd_pop[owner] = 1'b1;
               count_nxt     = count + CNT_W'(1);
            end
         end

         WAIT: begin
            if (bus_respcyc) begin
               if (tag_match) begin
                  take_beat = 1'b1;
               end else begin
                  tag_err = 1'b1;
               end
            end
         end

         RESP: begin
            take_beat = bus_respcyc;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // A matching response in WAIT is already beat 0, so WAIT and RESP
      // share the beat handling below.
      if (take_beat) begin
         bus_respack     = 1'b1;
         rs_valid[owner] = 1'b1;
         rs_data         = bus_resp;
         if (count == LAST_BEAT) begin
            rs_last     = 1'b1;
            done[owner] = 1'b1;
            count_nxt   = '0;
            state_nxt   = IDLE;
         end else begin
            count_nxt = count + CNT_W'(1);
            state_nxt = RESP;
         end
      end

      // Foreign responses are consumed so the bus cannot stall on them.
      if (tag_err) begin
         bus_respack = 1'b1;
      end
   end

endmodule

// File: doc/sysbus_arbiter.md
Name: sysbus_arbiter

Overview:
- Shares the single Sysbus request/response channel between two cache-line requesters: port 0 (instruction fetch) and port 1 (data side: loads and writebacks).
- Grants one requester at a time and drives the bus request phase.
- For writes, streams the write beats. For reads, routes the response beats back to the owning requester.
- Sits between the Core fetch/data units and the top-level Sysbus. Exactly one transaction is outstanding at a time.

Parameters:
- BEATS, 8, data beats per cache line (64-byte line / 8-byte beat).
- DATA_W, 64, width of address/data words on the bus.
- TAG_W, 13, bus tag width: {rw[1], type[4], id[8]}.

Ports:
- clk  in  1  bus clock.
- reset  in  1  asynchronous, active-high reset.
- rq_valid  in  2  per-port request pending; bit i = port i.
- rq_addr0, rq_addr1  in  DATA_W  line address per port; low 6 bits are ignored and forced to 0 on the bus.
- rq_type0, rq_type1  in  5  {rw, type} per port; rw=1 means write.
- rq_ack  out  2  one-cycle pulse: request for port i accepted by the bus.
- wd_data0, wd_data1  in  DATA_W  write beat supplied by port i.
- wd_pop  out  2  port i must present the next beat in the following cycle.
- rs_valid  out  2  response beat valid for port i.
- rs_data  out  DATA_W  response beat data (shared by both ports).
- rs_last  out  1  final beat of the line.
- done  out  2  one-cycle pulse: transaction of port i complete.
- bus_reqcyc  out  1  Sysbus reqcyc.
- bus_req  out  DATA_W  Sysbus req (address, then write data).
- bus_reqtag  out  TAG_W  Sysbus reqtag.
- bus_reqack  in  1  Sysbus reqack.
- bus_respcyc  in  1  Sysbus respcyc.
- bus_resp  in  DATA_W  Sysbus resp.
- bus_resptag  in  TAG_W  Sysbus resptag.
- bus_respack  out  1  Sysbus respack.

Behaviour:
- Reset (asynchronous): state=IDLE, owner=0, last_grant=1 (so port 0 wins the first tie), beat count=0. All outputs are 0.
- Clock/reset: one clock (clk). reset is asynchronous and active-high.
- States: IDLE, REQ, WDATA, WAIT, RESP.
- IDLE:
  - If any rq_valid is set, pick owner round-robin: if both are set, grant the port that is not last_grant; otherwise grant the single requester.
  - Register address, type, and owner; update last_grant; go to REQ.
- REQ:
  - Drive bus_reqcyc=1, bus_req=addr&~63, bus_reqtag={type, 7'b0, owner}.
  - Hold these until bus_reqack is sampled high.
  - On bus_reqack: pulse rq_ack[owner]. Go to WDATA if rw=1, else WAIT.
  - The requester must not change rq_addr/rq_type while waiting for rq_ack. It deasserts rq_valid the cycle after rq_ack.
- WDATA:
  - Registered-output timing: wd_pop[owner] is asserted in REQ's ack cycle and in each WDATA cycle except the last.
  - Each WDATA cycle: bus_reqcyc=1 and bus_req=wd_data of owner.
  - Exactly BEATS cycles, counter 0..BEATS-1.
  - After the final beat: pulse done[owner], go to IDLE. Writes produce no bus response.
- WAIT:
  - Outputs idle. On bus_respcyc with bus_resptag[7:0]==owner id, go to RESP and treat that cycle as beat 0.
  - A respcyc with a non-matching tag is acked and dropped, and the error flag asserts in simulation.
- RESP (beat 0 included):
  - Each cycle with bus_respcyc=1: bus_respack=1, rs_valid[owner]=1, rs_data=bus_resp (combinational pass-through), count++.
  - Cycles without respcyc are stalls: the count holds and rs_valid=0.
  - Beat BEATS-1: rs_last=1, pulse done[owner] the same cycle, go to IDLE.
- Count width is clog2(BEATS). It wraps to 0 on return to IDLE.
- Back-to-back: a new grant is allowed the cycle after done.
- Simultaneous events: rq_valid arriving during a transaction waits. It never preempts.
- Reset mid-transaction: returns to IDLE immediately. Outputs drop asynchronously and any partial line is abandoned. Requesters must re-issue.
- bus_respack is never asserted outside WAIT/RESP.

Test Plan:
- Single read, port 0, addr 0x1234 → bus_req=0x1200, reqtag={READ,MEMORY,8'h00}. Ack after 3 cycles gives rq_ack[0] one pulse. 8 resp beats 0..7 appear on rs_data with rs_valid[0]; rs_last and done[0] on beat 7.
- Both ports request in the same cycle after reset → port 0 granted first, port 1 the cycle after done[0]. With both held continuously, grants alternate 0,1,0,1.
- Port 1 write, addr 0x4000, beats 0xA0..0xA7 → bus_req sequence: 0x4000 (until ack), then 0xA0..0xA7 on 8 consecutive reqcyc cycles. done[1] after the 8th beat. bus_respack stays 0.
- Read response with 2 stall cycles between beats 3 and 4 → rs_valid drops during the stall, the beat count is preserved, and rs_last still lands on the 8th real beat.
- Reset asserted in RESP after beat 4 → all outputs 0 asynchronously. After reset release, a new port-0 request completes normally with the count starting at 0.
- Spurious respcyc in WAIT with tag id 0x01 while owner=0 → bus_respack=1, no rs_valid, and the block still awaits the owner's response.
